// File: rtl/serial_word_tx.sv
// rtl/serial_word_tx.sv - bit-serial word transmitter, MSB first, with frame strobe
//
// Ports:
//   clock      single clock, all state updates on posedge
//   reset_n    asynchronous active-low reset
//   in_data    parallel word to transmit (captured at acceptance)
//   in_valid   in_data is valid
//   in_ready   block accepts a word this cycle (IDLE only)
//   tx_enable  line-level gate; low holds the current bit
//   tx_data    serial data, MSB first
//   tx_frame   high while a word's bits are on tx_data
//   busy       high in SHIFT or GAP
//   done       one-cycle pulse after the last bit of a word is consumed
module serial_word_tx #(
   parameter int WIDTH = 32,
   parameter int GAP   = 1
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             tx_enable,
   output logic             tx_data,
   output logic             tx_frame,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH + 1);
   // GAP-1 is the largest gap count; keep at least one bit so GAP==1 still elaborates.
   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] shreg, shreg_n;
   logic [CW-1:0]    bit_cnt, bit_cnt_n;
   logic [GW-1:0]    gap_cnt, gap_cnt_n;
   logic             done_n;
   logic             frame_n;
   logic             data_n;
   logic             busy_n;
   logic             ready_n;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         shreg    <= '0;
         bit_cnt  <= '0;
         gap_cnt  <= '0;
         done     <= 1'b0;
         tx_frame <= 1'b0;
         tx_data  <= 1'b0;
         busy     <= 1'b0;
         in_ready <= 1'b1;
      end else begin
         state    <= state_n;
         shreg    <= shreg_n;
         bit_cnt  <= bit_cnt_n;
         gap_cnt  <= gap_cnt_n;
         done     <= done_n;
         tx_frame <= frame_n;
         tx_data  <= data_n;
         busy     <= busy_n;
         in_ready <= ready_n;
      end
   end

   always_comb begin
      state_n   = state;
      shreg_n   = shreg;
      bit_cnt_n = bit_cnt;
      gap_cnt_n = gap_cnt;
      done_n    = 1'b0;

      case (state)
         ST_IDLE: begin
            if (in_valid) begin
               shreg_n   = in_data;
               bit_cnt_n = CW'(WIDTH);
               state_n   = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (tx_enable) begin
               shreg_n   = {shreg[WIDTH-2:0], 1'b0};
               bit_cnt_n = bit_cnt - CW'(1);
               if (bit_cnt == CW'(1)) begin
                  done_n = 1'b1;
                  if (GAP > 1) begin
                     state_n   = ST_GAP;
                     gap_cnt_n = GW'(GAP - 1);
                  end else begin
                     state_n = ST_IDLE;
                  end
               end
            end
         end
         ST_GAP: begin
            // Counts down regardless of tx_enable; IDLE supplies the final low cycle.
            gap_cnt_n = gap_cnt - GW'(1);
            if (gap_cnt == GW'(1)) begin
               state_n = ST_IDLE;
            end
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase

      // Outputs are registered from the next state so they line up with it.
      frame_n = (state_n == ST_SHIFT);
      data_n  = (state_n == ST_SHIFT) ? shreg_n[WIDTH-1] : 1'b0;
      busy_n  = (state_n != ST_IDLE);
      ready_n = (state_n == ST_IDLE);
   end

endmodule

// File: tb/tb_serial_word_tx.sv
// tb/tb_serial_word_tx.sv - self-checking bench for serial_word_tx (GAP=1 and GAP=4 instances)
module tb_serial_word_tx;

   logic        clock = 1'b0;
   logic        reset_n;

   logic [31:0] in_data1, in_data4;
   logic        in_valid1, in_valid4;
   logic        in_ready1, in_ready4;
   logic        tx_enable1, tx_enable4;
   logic        tx_data1, tx_data4;
   logic        tx_frame1, tx_frame4;
   logic        busy1, busy4;
   logic        done1, done4;

   int pass_cnt = 0;
   int total_cnt = 0;

   always #5 clock = ~clock;

   serial_word_tx #(.WIDTH(32), .GAP(1)) dut1 (
      .clock(clock), .reset_n(reset_n),
      .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
      .tx_enable(tx_enable1), .tx_data(tx_data1), .tx_frame(tx_frame1),
      .busy(busy1), .done(done1)
   );

   serial_word_tx #(.WIDTH(32), .GAP(4)) dut4 (
      .clock(clock), .reset_n(reset_n),
      .in_data(in_data4), .in_valid(in_valid4), .in_ready(in_ready4),
      .tx_enable(tx_enable4), .tx_data(tx_data4), .tx_frame(tx_frame4),
      .busy(busy4), .done(done4)
   );

   typedef struct {
      logic [31:0] word;
      logic [31:0] exp_bits;
      int          drop_at;
      int          drop_len;
      int          exp_len;
      int          exp_held;
   } vec_t;

   vec_t vecs[5];

   logic fr[0:79];
   logic dt[0:79];
   logic rd[0:79];
   logic dn[0:79];
   logic bz[0:79];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Sends one word on dut1 and captures the frame. Enable is low for the edges
   // following frame cycles drop_at .. drop_at+drop_len-1.
   task automatic run1(input logic [31:0] word, input int drop_at, input int drop_len,
                       output logic [31:0] got, output int flen, output int held,
                       output int ndone, output int overlap, output logic first_done,
                       output logic first_ready);
      int c;
      logic en_prev;
      got = '0; flen = 0; held = 0; ndone = 0; overlap = 0;
      first_done = 1'b0; first_ready = 1'b0;
      in_data1 = word; in_valid1 = 1'b1; tx_enable1 = 1'b1;
      @(negedge clock);
      in_valid1 = 1'b0;
      in_data1 = ~word;
      en_prev = 1'b1;
      c = 0;
      while (tx_frame1 && c < 200) begin
         if (en_prev) got = {got[30:0], tx_data1};
         else held++;
         if (done1) overlap++;
         en_prev = !(c >= drop_at && c < drop_at + drop_len);
         tx_enable1 = en_prev;
         flen++;
         c++;
         @(negedge clock);
      end
      if (c >= 200) chk("frame_timeout", 1'b1, 1'b0);
      tx_enable1 = 1'b1;
      for (int j = 0; j < 3; j++) begin
         if (j == 0) begin
            first_done = done1;
            first_ready = in_ready1;
         end
         if (done1) ndone++;
         @(negedge clock);
      end
   endtask

   initial begin
      logic [31:0] got, a, b;
      int flen, held, ndone, overlap, nlow, nrdy, ndn;
      logic fd, frdy;

      vecs[0] = '{32'h12345678, 32'b0001_0010_0011_0100_0101_0110_0111_1000, 0, 0, 32, 0};
      vecs[1] = '{32'h55555555, 32'b0101_0101_0101_0101_0101_0101_0101_0101, 21, 3, 35, 3};
      vecs[2] = '{32'h80000001, 32'b1000_0000_0000_0000_0000_0000_0000_0001, 0, 0, 32, 0};
      vecs[3] = '{32'hA5C30F96, 32'b1010_0101_1100_0011_0000_1111_1001_0110, 0, 2, 34, 2};
      vecs[4] = '{32'hFFFFFFFF, 32'b1111_1111_1111_1111_1111_1111_1111_1111, 31, 1, 33, 1};

      in_data1 = '0; in_valid1 = 1'b0; tx_enable1 = 1'b1;
      in_data4 = '0; in_valid4 = 1'b0; tx_enable4 = 1'b1;
      reset_n = 1'b1;
      #2 reset_n = 1'b0;
      #1;
      chk("rst_tx_data", tx_data1, 1'b0);
      chk("rst_tx_frame", tx_frame1, 1'b0);
      chk("rst_busy", busy1, 1'b0);
      chk("rst_done", done1, 1'b0);
      chk("rst_in_ready", in_ready1, 1'b1);
      chk("rst_in_ready_g4", in_ready4, 1'b1);
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);

      for (int v = 0; v < 5; v++) begin
         run1(vecs[v].word, vecs[v].drop_at, vecs[v].drop_len, got, flen, held, ndone, overlap, fd, frdy);
         chk($sformatf("vec%0d_bits", v), got, vecs[v].exp_bits);
         chk($sformatf("vec%0d_frame_len", v), flen, vecs[v].exp_len);
         chk($sformatf("vec%0d_held", v), held, vecs[v].exp_held);
         chk($sformatf("vec%0d_done_count", v), ndone, 1);
         chk($sformatf("vec%0d_done_first_low", v), fd, 1'b1);
         chk($sformatf("vec%0d_done_in_frame", v), overlap, 0);
         chk($sformatf("vec%0d_ready_after", v), frdy, 1'b1);
      end

      // Back-to-back on GAP=1 with in_valid held across both words.
      in_data1 = 32'h12345678; in_valid1 = 1'b1;
      @(negedge clock);
      in_data1 = 32'h55555555;
      for (int c = 0; c < 80; c++) begin
         fr[c] = tx_frame1; dt[c] = tx_data1; rd[c] = in_ready1; dn[c] = done1;
         if (c == 33) in_valid1 = 1'b0;
         @(negedge clock);
      end
      a = '0; b = '0; nlow = 0; nrdy = 0;
      for (int c = 0; c < 32; c++) a = {a[30:0], dt[c]};
      for (int c = 33; c < 65; c++) b = {b[30:0], dt[c]};
      for (int c = 0; c < 65; c++) begin
         if (!fr[c]) nlow++;
         if (rd[c]) nrdy++;
      end
      chk("b2b_word1", a, 32'h12345678);
      chk("b2b_word2", b, 32'h55555555);
      chk("b2b_low_cycles", nlow, 1);
      chk("b2b_ready_count", nrdy, 1);
      chk("b2b_ready_idle", rd[32], 1'b1);
      chk("b2b_done_idle", dn[32], 1'b1);
      chk("b2b_frame2_end", fr[65], 1'b0);

      // Reset in the middle of a frame of 32'hFFFF0000, at bit 16.
      in_data1 = 32'hFFFF0000; in_valid1 = 1'b1;
      @(negedge clock);
      in_valid1 = 1'b0;
      repeat (15) @(negedge clock);
      chk("midrst_pre_data", tx_data1, 1'b1);
      chk("midrst_pre_frame", tx_frame1, 1'b1);
      reset_n = 1'b0;
      #1;
      chk("midrst_tx_data", tx_data1, 1'b0);
      chk("midrst_tx_frame", tx_frame1, 1'b0);
      chk("midrst_busy", busy1, 1'b0);
      chk("midrst_in_ready", in_ready1, 1'b1);
      ndn = 0;
      for (int j = 0; j < 3; j++) begin
         @(negedge clock);
         if (done1 || tx_frame1) ndn++;
      end
      reset_n = 1'b1;
      for (int j = 0; j < 4; j++) begin
         @(negedge clock);
         if (done1 || tx_frame1) ndn++;
      end
      chk("midrst_no_done_or_frame", ndn, 0);
      run1(32'h12345678, 0, 0, got, flen, held, ndone, overlap, fd, frdy);
      chk("midrst_next_bits", got, 32'h12345678);
      chk("midrst_next_len", flen, 32);
      chk("midrst_next_done", ndone, 1);

      // GAP=4: in_data changes right after each acceptance.
      in_data4 = 32'h0F0FA5A5; in_valid4 = 1'b1;
      @(negedge clock);
      in_data4 = 32'h3C3C1234;
      for (int c = 0; c < 80; c++) begin
         fr[c] = tx_frame4; dt[c] = tx_data4; rd[c] = in_ready4; dn[c] = done4; bz[c] = busy4;
         if (c == 36) begin
            in_valid4 = 1'b0;
            in_data4 = 32'hC3C3EDCB;
         end
         @(negedge clock);
      end
      a = '0; b = '0; nlow = 0; nrdy = 0; ndn = 0;
      for (int c = 0; c < 32; c++) a = {a[30:0], dt[c]};
      for (int c = 36; c < 68; c++) b = {b[30:0], dt[c]};
      for (int c = 0; c < 68; c++) begin
         if (!fr[c]) nlow++;
         if (rd[c]) nrdy++;
      end
      for (int c = 0; c < 80; c++) if (dn[c]) ndn++;
      chk("g4_word1", a, 32'h0F0FA5A5);
      chk("g4_word2", b, 32'h3C3C1234);
      chk("g4_low_cycles", nlow, 4);
      chk("g4_ready_count", nrdy, 1);
      chk("g4_ready_cycle", rd[35], 1'b1);
      chk("g4_busy_gap", bz[33], 1'b1);
      chk("g4_gap_data", dt[33], 1'b0);
      chk("g4_done_first", dn[32], 1'b1);
      chk("g4_done_count", ndn, 2);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
